// File: rtl/cpu_run_controller.sv
// Run/debug controller between the board clock/reset and a single-cycle core.
// It sequences the core reset, then gates execution through Cpu_en.
// Supported modes are free-run, single-step, cycle-limited run and halt.
// It also provides PC breakpoints and a saturating cycle counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET_SEQ | core held in reset for RESET_CYCLES edges after Rst release
// IDLE      | core out of reset, not executing, waiting for a request
// RUN       | core executing until a breakpoint, the limit or Mode=11
// STEP      | exactly one enabled cycle, no breakpoint check
// HALTED    | stopped; Halt_cause/Bp_hit describe why
module cpu_run_controller #(
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_BP       = 2,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [1:0]                   Mode,
  input  logic                         Run_req,
  input  logic                         Step_req,
  input  logic [CNT_WIDTH-1:0]         Cycle_limit,
  input  logic [NUM_BP-1:0]            Bp_enable,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] Bp_addr,
  input  logic [ADDR_WIDTH-1:0]        Pc_out,
  output logic                         Cpu_rst,
  output logic                         Cpu_en,
  output logic [2:0]                   State,
  output logic [CNT_WIDTH-1:0]         Cycle_count,
  output logic                         Halted,
  output logic [1:0]                   Halt_cause,
  output logic [NUM_BP-1:0]            Bp_hit
);

  typedef enum logic [2:0] {
    RESET_SEQ = 3'd0,
    IDLE      = 3'd1,
    RUN       = 3'd2,
    STEP      = 3'd3,
    HALTED    = 3'd4
  } state_t;

  localparam int RST_CNT_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
  localparam logic [RST_CNT_W-1:0] RST_CNT_LAST = RST_CNT_W'(RESET_CYCLES - 1);

  localparam logic [1:0] MODE_FREE  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_LIMIT = 2'b10;
  localparam logic [1:0] MODE_HALT  = 2'b11;

  localparam logic [1:0] CAUSE_STEP  = 2'd0;
  localparam logic [1:0] CAUSE_BP    = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_EXT   = 2'd3;

  state_t                 state_q, state_d;
  logic [RST_CNT_W-1:0]   rst_cnt_q;
  logic                   cpu_rst_q;
  logic                   skip_q;
  logic                   set_skip;
  logic [CNT_WIDTH-1:0]   cycle_count_q;
  logic [1:0]             halt_cause_q, halt_cause_d;
  logic [NUM_BP-1:0]      bp_hit_q, bp_hit_d;
  logic [NUM_BP-1:0]      bp_vec;
  logic                   bp_match;
  logic                   lim;
  logic                   run_ok;
  logic                   cpu_en;

  // Per-comparator breakpoint match; suppressed on the first cycle after a
  // resume so the core can leave the PC it stopped on.
  always_comb begin
    bp_vec = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_vec[i] = Bp_enable[i] && !skip_q &&
                  (Pc_out == Bp_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  assign bp_match = |bp_vec;
  assign lim      = (Mode == MODE_LIMIT) && (cycle_count_q >= Cycle_limit);
  assign run_ok   = Run_req && ((Mode == MODE_FREE) || (Mode == MODE_LIMIT));

  // Next-state, enable and halt-status decode.
  always_comb begin
    state_d      = state_q;
    cpu_en       = 1'b0;
    set_skip     = 1'b0;
    halt_cause_d = halt_cause_q;
    bp_hit_d     = bp_hit_q;
    case (state_q)
      RESET_SEQ: begin
        if (rst_cnt_q == RST_CNT_LAST) state_d = IDLE;
      end
      IDLE: begin
        if (Step_req && (Mode == MODE_STEP)) state_d = STEP;
        else if (run_ok)                     state_d = RUN;
      end
      RUN: begin
        cpu_en = !bp_match && !lim && (Mode != MODE_HALT);
        if (bp_match) begin
          state_d      = HALTED;
          halt_cause_d = CAUSE_BP;
          bp_hit_d     = bp_vec;
        end else if (lim) begin
          state_d      = HALTED;
          halt_cause_d = CAUSE_LIMIT;
        end else if (Mode == MODE_HALT) begin
          state_d      = HALTED;
          halt_cause_d = CAUSE_EXT;
        end
      end
      STEP: begin
        cpu_en       = 1'b1;
        state_d      = HALTED;
        halt_cause_d = CAUSE_STEP;
      end
      HALTED: begin
        // A step only loses to a simultaneous run request outside step mode.
        if (Step_req && ((Mode == MODE_STEP) || !run_ok)) begin
          state_d  = STEP;
          bp_hit_d = '0;
        end else if (run_ok) begin
          state_d  = RUN;
          set_skip = 1'b1;
          bp_hit_d = '0;
        end
      end
      default: state_d = RESET_SEQ;
    endcase
  end

  // State register, reset sequencer and halt status.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= RESET_SEQ;
      rst_cnt_q    <= '0;
      cpu_rst_q    <= 1'b1;
      skip_q       <= 1'b0;
      halt_cause_q <= CAUSE_STEP;
      bp_hit_q     <= '0;
    end else begin
      state_q      <= state_d;
      cpu_rst_q    <= (state_d == RESET_SEQ);
      halt_cause_q <= halt_cause_d;
      bp_hit_q     <= bp_hit_d;
      if (state_q == RESET_SEQ) rst_cnt_q <= rst_cnt_q + 1'b1;
      if (set_skip)             skip_q <= 1'b1;
      else if (state_q == RUN)  skip_q <= 1'b0;
    end
  end

  // Saturating count of enabled cycles.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cycle_count_q <= '0;
    end else if (cpu_en && (cycle_count_q != {CNT_WIDTH{1'b1}})) begin
      cycle_count_q <= cycle_count_q + 1'b1;
    end
  end

  assign Cpu_rst     = cpu_rst_q;
  assign Cpu_en      = cpu_en;
  assign State       = state_q;
  assign Cycle_count = cycle_count_q;
  assign Halted      = (state_q == HALTED);
  assign Halt_cause  = halt_cause_q;
  assign Bp_hit      = bp_hit_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: stimulus queues the expected
// halt record, a negedge monitor checks it whenever Halted rises.
module tb_cpu_run_controller;

  localparam int AW = 32;
  localparam int NB = 2;
  localparam int CW = 8;

  logic           Clk = 1'b0;
  logic           Rst = 1'b0;
  logic [1:0]     Mode = 2'b11;
  logic           Run_req = 1'b0;
  logic           Step_req = 1'b0;
  logic [CW-1:0]  Cycle_limit = '0;
  logic [NB-1:0]  Bp_enable = '0;
  logic [NB*AW-1:0] Bp_addr = '0;
  logic [AW-1:0]  Pc_out;
  logic           Cpu_rst;
  logic           Cpu_en;
  logic [2:0]     State;
  logic [CW-1:0]  Cycle_count;
  logic           Halted;
  logic [1:0]     Halt_cause;
  logic [NB-1:0]  Bp_hit;

  cpu_run_controller #(
    .ADDR_WIDTH(AW), .NUM_BP(NB), .CNT_WIDTH(CW), .RESET_CYCLES(4)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Mode(Mode), .Run_req(Run_req), .Step_req(Step_req),
    .Cycle_limit(Cycle_limit), .Bp_enable(Bp_enable), .Bp_addr(Bp_addr),
    .Pc_out(Pc_out), .Cpu_rst(Cpu_rst), .Cpu_en(Cpu_en), .State(State),
    .Cycle_count(Cycle_count), .Halted(Halted), .Halt_cause(Halt_cause),
    .Bp_hit(Bp_hit)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]    cause;
    logic [NB-1:0] bp;
    logic [CW-1:0] cnt;
    int            en;
    logic [AW-1:0] pc;
    bit            chk_en;
    bit            chk_pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   en_run = 0;
  bit   prev_h = 1'b0;
  bit   en_s = 1'b0;
  logic [AW-1:0] pc = '0;

  assign Pc_out = pc;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Core model: PC advances by 4 on each enabled cycle.
  always @(posedge Clk or negedge Rst) begin
    if (!Rst)         pc <= '0;
    else if (Cpu_rst) pc <= '0;
    else if (en_s)    pc <= pc + 32'd4;
  end

  // Monitor: count enabled cycles and check each halt against the scoreboard.
  always @(negedge Clk) begin
    en_s = Cpu_en;
    if (!Rst) begin
      prev_h = 1'b0;
      en_run = 0;
    end else begin
      if (Cpu_en) en_run++;
      if (Halted && !prev_h) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_halt: got cause %0d expected no halt", Halt_cause);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("halt_cause", Halt_cause, e.cause);
          chk("bp_hit", Bp_hit, e.bp);
          chk("cycle_count", Cycle_count, e.cnt);
          if (e.chk_en) chk("enabled_cycles", en_run, e.en);
          if (e.chk_pc) chk("halt_pc", pc, e.pc);
        end
        en_run = 0;
      end
      prev_h = Halted;
    end
  end

  function automatic exp_t mk(input logic [1:0] c, input logic [NB-1:0] b,
                              input logic [CW-1:0] n, input int en,
                              input logic [AW-1:0] p, input bit ce, input bit cp);
    exp_t e;
    e.cause = c; e.bp = b; e.cnt = n; e.en = en; e.pc = p;
    e.chk_en = ce; e.chk_pc = cp;
    return e;
  endfunction

  task automatic do_reset();
    Rst = 1'b0;
    Run_req = 1'b0;
    Step_req = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_state", State, 0);
    chk("rst_cpu_rst", Cpu_rst, 1);
    chk("rst_cpu_en", Cpu_en, 0);
    chk("rst_count", Cycle_count, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_bp_hit", Bp_hit, 0);
    Rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge Clk);
      #1;
      if (k < 4) begin
        chk("rst_hold", Cpu_rst, 1);
      end else begin
        chk("rst_release", Cpu_rst, 0);
        chk("idle_state", State, 1);
        chk("idle_cpu_en", Cpu_en, 0);
      end
    end
  endtask

  task automatic pulse_run();
    Run_req = 1'b1;
    @(posedge Clk);
    #1;
    Run_req = 1'b0;
  endtask

  task automatic pulse_step();
    Step_req = 1'b1;
    @(posedge Clk);
    #1;
    Step_req = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge Clk);
      #1;
      ok = Halted;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL halt_timeout: got no halt within %0d cycles expected halt", budget);
    end
    @(negedge Clk);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset sequence and breakpoint halt, then resume past the breakpoint.
    do_reset();
    Mode = 2'b00;
    Bp_enable = 2'b01;
    Bp_addr[0 +: AW] = 32'h10;
    exp_q.push_back(mk(2'd1, 2'b01, 8'd4, 4, 32'h10, 1'b1, 1'b1));
    pulse_run();
    wait_halt(50);
    exp_q.push_back(mk(2'd3, 2'b00, 8'd7, 3, 32'h1C, 1'b1, 1'b1));
    pulse_run();
    repeat (3) @(posedge Clk);
    #1;
    Mode = 2'b11;
    wait_halt(20);

    // Cycle limit 7, then limit 0 resumes into an immediate halt.
    do_reset();
    Mode = 2'b10;
    Bp_enable = 2'b00;
    Cycle_limit = 8'd7;
    exp_q.push_back(mk(2'd2, 2'b00, 8'd7, 7, 32'h1C, 1'b1, 1'b1));
    pulse_run();
    wait_halt(50);
    Cycle_limit = 8'd0;
    exp_q.push_back(mk(2'd2, 2'b00, 8'd7, 0, 32'h1C, 1'b1, 1'b1));
    pulse_run();
    wait_halt(20);

    // Three single steps spaced five cycles apart.
    do_reset();
    Mode = 2'b01;
    for (int s = 1; s <= 3; s++) begin
      exp_q.push_back(mk(2'd0, 2'b00, CW'(s), 1, AW'(4 * s), 1'b1, 1'b1));
      pulse_step();
      repeat (4) @(posedge Clk);
      #1;
    end

    // Both breakpoints and the limit coincide: breakpoint wins.
    do_reset();
    Mode = 2'b10;
    Cycle_limit = 8'd2;
    Bp_enable = 2'b11;
    Bp_addr = {32'h8, 32'h8};
    exp_q.push_back(mk(2'd1, 2'b11, 8'd2, 2, 32'h8, 1'b1, 1'b1));
    pulse_run();
    wait_halt(30);

    // Counter saturation during a long free run.
    do_reset();
    Mode = 2'b00;
    Bp_enable = 2'b00;
    pulse_run();
    repeat (300) @(posedge Clk);
    #1;
    chk("sat_count", Cycle_count, 8'hFF);
    chk("sat_cpu_en", Cpu_en, 1);
    exp_q.push_back(mk(2'd3, 2'b00, 8'hFF, 0, 32'h0, 1'b0, 1'b0));
    Mode = 2'b11;
    wait_halt(20);

    // Asynchronous reset between edges while running.
    do_reset();
    Mode = 2'b00;
    pulse_run();
    repeat (3) @(posedge Clk);
    #3;
    chk("pre_async_cpu_en", Cpu_en, 1);
    Rst = 1'b0;
    #1;
    chk("async_cpu_rst", Cpu_rst, 1);
    chk("async_cpu_en", Cpu_en, 0);
    chk("async_count", Cycle_count, 0);
    chk("async_state", State, 0);
    do_reset();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
